// File: rtl/ibex_fpu_issue_ctrl.sv
// In-order FP issue scheduler: classifies ops by latency, starts the matching unit and
// reserves the shared writeback slot. Optional feature macro: IBEX_FPU_OPCHECK_EN.

package ibex_fp_pkg;

  typedef enum logic [5:0] {
    FPU_ADD,
    FPU_SUB,
    FPU_MUL,
    FPU_MADD,
    FPU_MSUB,
    FPU_NMADD,
    FPU_NMSUB,
    FPU_DIV,
    FPU_SQRT,
    FPU_MIN,
    FPU_MAX,
    FPU_SGNJ,
    FPU_SGNJ_N,
    FPU_SGNJ_X,
    FPU_INT2FLOAT,
    FPU_INT2FLOAT_U,
    FPU_FLOAT2INT,
    FPU_FLOAT2INT_U,
    FPU_MOVE_INT2FLOAT,
    FPU_MOVE_FLOAT2INT,
    FPU_CMP_EQ,
    FPU_CMP_LT,
    FPU_CMP_LE,
    FCLASS,
    FPU_NOP
  } fpu_op_e;

endpackage

module ibex_fpu_issue_ctrl #(
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12,
  parameter int TAG_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [5:0]       req_op_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             add_start_o,
  output logic             mul_start_o,
  output logic             div_start_o,
  output logic             misc_start_o,
  output logic [5:0]       unit_op_o,
  output logic             unit_kill_o,
  output logic             wb_valid_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             wb_illegal_o,
  output logic             busy_div_o,
  output logic             idle_o
);

  import ibex_fp_pkg::*;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ADD,
    CLS_MUL,
    CLS_DIV,
    CLS_MISC,
    CLS_ILL
  } op_cls_e;

  op_cls_e                       cls;
  logic [5:0]                    lat;
  logic [DIV_LAT-1:0]            res_v;
  logic [DIV_LAT-1:0]            sh_v;
  logic [DIV_LAT-1:0][TAG_W-1:0] res_tag;
  logic [DIV_LAT-1:0][TAG_W-1:0] sh_tag;
  logic [DIV_LAT-1:0]            wr_slot;
  logic [4:0]                    div_cnt;
  logic                          slot_busy;
  logic                          div_free;
  logic                          issue;
  logic                          wr_en;

  always_comb begin
    cls = CLS_NONE;
    case (req_op_i)
      FPU_ADD, FPU_SUB, FPU_INT2FLOAT, FPU_INT2FLOAT_U,
      FPU_FLOAT2INT, FPU_FLOAT2INT_U:                      cls = CLS_ADD;
      FPU_MUL, FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB:   cls = CLS_MUL;
      FPU_DIV, FPU_SQRT:                                   cls = CLS_DIV;
      FPU_MIN, FPU_MAX, FPU_SGNJ, FPU_SGNJ_N, FPU_SGNJ_X,
      FPU_MOVE_INT2FLOAT, FPU_MOVE_FLOAT2INT,
      FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FCLASS:          cls = CLS_MISC;
      FPU_NOP:                                             cls = CLS_NONE;
`ifdef IBEX_FPU_OPCHECK_EN
      default:                                             cls = CLS_ILL;
`else
      default:                                             cls = CLS_NONE;
`endif
    endcase
  end

  always_comb begin
    lat = 6'd0;
    case (cls)
      CLS_ADD:            lat = 6'(ADD_LAT);
      CLS_MUL:            lat = 6'(MUL_LAT);
      CLS_DIV:            lat = 6'(DIV_LAT);
      CLS_MISC, CLS_ILL:  lat = 6'd1;
      default:            lat = 6'd0;
    endcase
  end

  // Reservation contents as they will look after this cycle's shift; slot k+1 lands in k.
  assign sh_v   = {1'b0, res_v[DIV_LAT-1:1]};
  assign sh_tag = {{TAG_W{1'b0}}, res_tag[DIV_LAT-1:1]};

  always_comb begin
    slot_busy = 1'b0;
    wr_slot   = '0;
    for (int k = 0; k < DIV_LAT; k++) begin
      if (lat == 6'(k + 1)) begin
        slot_busy  = sh_v[k];
        wr_slot[k] = wr_en;
      end
    end
  end

  // The divider may accept a new op in the writeback cycle of the previous one (count 1).
  assign div_free    = (div_cnt <= 5'd1);
  assign req_ready_o = ~rst_i & ~flush_i & ~slot_busy & ((cls != CLS_DIV) | div_free);
  assign issue       = req_valid_i & req_ready_o;
  assign wr_en       = issue & (cls != CLS_NONE);

  assign add_start_o  = issue & (cls == CLS_ADD);
  assign mul_start_o  = issue & (cls == CLS_MUL);
  assign div_start_o  = issue & (cls == CLS_DIV);
  assign misc_start_o = issue & (cls == CLS_MISC);
  assign unit_op_o    = (add_start_o | mul_start_o | div_start_o | misc_start_o) ? req_op_i : 6'd0;
  assign unit_kill_o  = flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      res_v   <= '0;
      res_tag <= '0;
      div_cnt <= '0;
    end else begin
      for (int k = 0; k < DIV_LAT; k++) begin
        res_v[k]   <= wr_slot[k] | sh_v[k];
        res_tag[k] <= wr_slot[k] ? req_tag_i : sh_tag[k];
      end
      if (div_start_o) begin
        div_cnt <= 5'(DIV_LAT);
      end else if (div_cnt != 5'd0) begin
        div_cnt <= div_cnt - 5'd1;
      end
    end
  end

  assign wb_valid_o = res_v[0] & ~flush_i & ~rst_i;
  assign wb_tag_o   = res_tag[0];

  // Count reaches 1 in the divider's writeback cycle; a back-to-back DIV keeps busy high there.
  assign busy_div_o = (div_cnt > 5'd1) | ((div_cnt == 5'd1) & div_start_o);
  assign idle_o     = ~(|res_v) & ~busy_div_o;

`ifdef IBEX_FPU_OPCHECK_EN
  logic [DIV_LAT-1:0] res_ill;
  logic [DIV_LAT-1:0] sh_ill;

  assign sh_ill = {1'b0, res_ill[DIV_LAT-1:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      res_ill <= '0;
    end else begin
      for (int k = 0; k < DIV_LAT; k++) begin
        res_ill[k] <= wr_slot[k] ? (cls == CLS_ILL) : sh_ill[k];
      end
    end
  end

  assign wb_illegal_o = res_ill[0] & wb_valid_o;
`else
  assign wb_illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_fpu_issue_ctrl.sv
// Directed bench for ibex_fpu_issue_ctrl: one task per scenario, inline expected values.
module tb_ibex_fpu_issue_ctrl;
  import ibex_fp_pkg::*;

  localparam int TAG_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [5:0]       req_op_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             flush_i;
  logic             add_start_o, mul_start_o, div_start_o, misc_start_o;
  logic [5:0]       unit_op_o;
  logic             unit_kill_o;
  logic             wb_valid_o;
  logic [TAG_W-1:0] wb_tag_o;
  logic             wb_illegal_o;
  logic             busy_div_o;
  logic             idle_o;
  logic [3:0]       starts;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  assign starts = {add_start_o, mul_start_o, div_start_o, misc_start_o};

  ibex_fpu_issue_ctrl #(.ADD_LAT(3), .MUL_LAT(4), .DIV_LAT(12), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
    .add_start_o(add_start_o), .mul_start_o(mul_start_o), .div_start_o(div_start_o),
    .misc_start_o(misc_start_o), .unit_op_o(unit_op_o), .unit_kill_o(unit_kill_o),
    .wb_valid_o(wb_valid_o), .wb_tag_o(wb_tag_o), .wb_illegal_o(wb_illegal_o),
    .busy_div_o(busy_div_o), .idle_o(idle_o)
  );

  task automatic drive(input logic v, input logic [5:0] op, input logic [TAG_W-1:0] tag,
                       input logic fl);
    req_valid_i = v;
    req_op_i    = op;
    req_tag_i   = tag;
    flush_i     = fl;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    logic [9:0] obs;
    rst_i = 1'b1;
    drive(1'b1, FPU_ADD, 5'd3, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      obs = {req_ready_o, starts, unit_kill_o, wb_valid_o, wb_illegal_o, busy_div_o, idle_o};
      total++; if (obs !== 10'b0000000001) begin bad++; $display("FAIL reset outputs c=%0d got=%b exp=%b", c, obs, 10'b0000000001); end
      total++; if (wb_tag_o !== 5'd0) begin bad++; $display("FAIL reset wb_tag c=%0d got=%0d exp=0", c, wb_tag_o); end
      tick();
    end
    rst_i = 1'b0;
    drive(1'b0, FPU_ADD, 5'd0, 1'b0);
    @(negedge clk_i);
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL reset idle_after got=%b exp=1", idle_o); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset ready_after got=%b exp=1", req_ready_o); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic exp_wb;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) drive(1'b1, FPU_ADD, TAG_W'(c + 1), 1'b0);
      else       drive(1'b0, FPU_NOP, 5'd0, 1'b0);
      @(negedge clk_i);
      total++; if (starts !== ((c < 3) ? 4'b1000 : 4'b0000)) begin bad++; $display("FAIL b2b starts c=%0d got=%b exp=%b", c, starts, (c < 3) ? 4'b1000 : 4'b0000); end
      if (c < 3) begin
        total++; if (unit_op_o !== FPU_ADD) begin bad++; $display("FAIL b2b unit_op c=%0d got=%0d exp=%0d", c, unit_op_o, FPU_ADD); end
      end
      exp_wb = (c >= 3) && (c <= 5);
      total++; if (wb_valid_o !== exp_wb) begin bad++; $display("FAIL b2b wb_valid c=%0d got=%b exp=%b", c, wb_valid_o, exp_wb); end
      if (exp_wb) begin
        total++; if (wb_tag_o !== TAG_W'(c - 2)) begin bad++; $display("FAIL b2b wb_tag c=%0d got=%0d exp=%0d", c, wb_tag_o, c - 2); end
      end
      tick();
    end
  endtask

  task automatic test_collision;
    logic [3:0] exp_st;
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      drive(1'b1, FPU_MUL, 5'd7, 1'b0);
      else if (c <= 2) drive(1'b1, FPU_ADD, 5'd8, 1'b0);
      else             drive(1'b0, FPU_NOP, 5'd0, 1'b0);
      @(negedge clk_i);
      if (c <= 2) begin
        total++; if (req_ready_o !== (c != 1)) begin bad++; $display("FAIL coll ready c=%0d got=%b exp=%b", c, req_ready_o, c != 1); end
      end
      exp_st = (c == 0) ? 4'b0100 : (c == 2) ? 4'b1000 : 4'b0000;
      total++; if (starts !== exp_st) begin bad++; $display("FAIL coll starts c=%0d got=%b exp=%b", c, starts, exp_st); end
      total++; if (wb_valid_o !== (c == 4 || c == 5)) begin bad++; $display("FAIL coll wb_valid c=%0d got=%b exp=%b", c, wb_valid_o, c == 4 || c == 5); end
      if (c == 4 || c == 5) begin
        total++; if (wb_tag_o !== ((c == 4) ? 5'd7 : 5'd8)) begin bad++; $display("FAIL coll wb_tag c=%0d got=%0d exp=%0d", c, wb_tag_o, (c == 4) ? 7 : 8); end
      end
      tick();
    end
  endtask

  task automatic test_div_occupancy;
    logic exp_wb;
    for (int c = 0; c < 26; c++) begin
      if (c == 0)       drive(1'b1, FPU_DIV, 5'd4, 1'b0);
      else if (c <= 12) drive(1'b1, FPU_SQRT, 5'd5, 1'b0);
      else              drive(1'b0, FPU_NOP, 5'd0, 1'b0);
      @(negedge clk_i);
      if (c <= 12) begin
        total++; if (req_ready_o !== (c == 0 || c == 12)) begin bad++; $display("FAIL div ready c=%0d got=%b exp=%b", c, req_ready_o, c == 0 || c == 12); end
      end
      total++; if (div_start_o !== (c == 0 || c == 12)) begin bad++; $display("FAIL div start c=%0d got=%b exp=%b", c, div_start_o, c == 0 || c == 12); end
      if (c == 12) begin
        total++; if (unit_op_o !== FPU_SQRT) begin bad++; $display("FAIL div unit_op c=%0d got=%0d exp=%0d", c, unit_op_o, FPU_SQRT); end
      end
      total++; if (busy_div_o !== (c >= 1 && c <= 23)) begin bad++; $display("FAIL div busy c=%0d got=%b exp=%b", c, busy_div_o, c >= 1 && c <= 23); end
      exp_wb = (c == 12) || (c == 24);
      total++; if (wb_valid_o !== exp_wb) begin bad++; $display("FAIL div wb_valid c=%0d got=%b exp=%b", c, wb_valid_o, exp_wb); end
      if (exp_wb) begin
        total++; if (wb_tag_o !== ((c == 12) ? 5'd4 : 5'd5)) begin bad++; $display("FAIL div wb_tag c=%0d got=%0d exp=%0d", c, wb_tag_o, (c == 12) ? 4 : 5); end
      end
      tick();
    end
  endtask

  task automatic test_flush_div;
    for (int c = 0; c < 14; c++) begin
      if (c == 0)      drive(1'b1, FPU_DIV, 5'd2, 1'b0);
      else if (c == 5) drive(1'b1, FPU_ADD, 5'd3, 1'b1);
      else             drive(1'b0, FPU_NOP, 5'd0, 1'b0);
      @(negedge clk_i);
      total++; if (unit_kill_o !== (c == 5)) begin bad++; $display("FAIL flush kill c=%0d got=%b exp=%b", c, unit_kill_o, c == 5); end
      total++; if (busy_div_o !== (c >= 1 && c <= 5)) begin bad++; $display("FAIL flush busy c=%0d got=%b exp=%b", c, busy_div_o, c >= 1 && c <= 5); end
      total++; if (idle_o !== (c == 0 || c >= 6)) begin bad++; $display("FAIL flush idle c=%0d got=%b exp=%b", c, idle_o, c == 0 || c >= 6); end
      total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL flush wb_valid c=%0d got=%b exp=0", c, wb_valid_o); end
      if (c == 5) begin
        total++; if ({req_ready_o, add_start_o} !== 2'b00) begin bad++; $display("FAIL flush blocked_issue got=%b exp=00", {req_ready_o, add_start_o}); end
      end
      tick();
    end
  endtask

  task automatic test_flush_wb;
    for (int c = 0; c < 3; c++) begin
      if (c == 0)      drive(1'b1, FPU_MIN, 5'd6, 1'b0);
      else if (c == 1) drive(1'b0, FPU_NOP, 5'd0, 1'b1);
      else             drive(1'b0, FPU_NOP, 5'd0, 1'b0);
      @(negedge clk_i);
      if (c == 0) begin
        total++; if (misc_start_o !== 1'b1) begin bad++; $display("FAIL flushwb misc_start got=%b exp=1", misc_start_o); end
      end
      total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL flushwb wb_valid c=%0d got=%b exp=0", c, wb_valid_o); end
      tick();
    end
  endtask

  task automatic test_classes;
    logic [5:0] t_op  [8] = '{FPU_CMP_LT, FPU_NOP, FPU_INT2FLOAT_U, FPU_NMSUB,
                              FCLASS, FPU_MOVE_FLOAT2INT, FPU_FLOAT2INT, FPU_MSUB};
    logic [3:0] t_st  [8] = '{4'b0001, 4'b0000, 4'b1000, 4'b0100,
                              4'b0001, 4'b0001, 4'b1000, 4'b0100};
    int         t_lat [8] = '{1, 0, 3, 4, 1, 1, 3, 4};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, t_op[i], TAG_W'(10 + i), 1'b0);
      @(negedge clk_i);
      total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL class ready i=%0d got=%b exp=1", i, req_ready_o); end
      total++; if (starts !== t_st[i]) begin bad++; $display("FAIL class starts i=%0d got=%b exp=%b", i, starts, t_st[i]); end
      total++; if (unit_op_o !== ((t_st[i] != 4'b0000) ? t_op[i] : 6'd0)) begin bad++; $display("FAIL class unit_op i=%0d got=%0d exp=%0d", i, unit_op_o, (t_st[i] != 4'b0000) ? t_op[i] : 6'd0); end
      tick();
      for (int d = 1; d <= 5; d++) begin
        drive(1'b0, FPU_NOP, 5'd0, 1'b0);
        @(negedge clk_i);
        total++; if (wb_valid_o !== (d == t_lat[i])) begin bad++; $display("FAIL class wb_valid i=%0d d=%0d got=%b exp=%b", i, d, wb_valid_o, d == t_lat[i]); end
        if (d == t_lat[i]) begin
          total++; if (wb_tag_o !== TAG_W'(10 + i)) begin bad++; $display("FAIL class wb_tag i=%0d got=%0d exp=%0d", i, wb_tag_o, 10 + i); end
        end
        total++; if (wb_illegal_o !== 1'b0) begin bad++; $display("FAIL class wb_illegal i=%0d d=%0d got=%b exp=0", i, d, wb_illegal_o); end
        tick();
      end
    end
  endtask

  task automatic test_illegal;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1'b1, 6'd40, 5'd9, 1'b0);
      else        drive(1'b0, FPU_NOP, 5'd0, 1'b0);
      @(negedge clk_i);
      if (c == 0) begin
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL illegal ready got=%b exp=1", req_ready_o); end
        total++; if (starts !== 4'b0000) begin bad++; $display("FAIL illegal starts got=%b exp=0000", starts); end
      end
`ifdef IBEX_FPU_OPCHECK_EN
      total++; if ({wb_valid_o, wb_illegal_o} !== ((c == 1) ? 2'b11 : 2'b00)) begin bad++; $display("FAIL illegal wb c=%0d got=%b exp=%b", c, {wb_valid_o, wb_illegal_o}, (c == 1) ? 2'b11 : 2'b00); end
      if (c == 1) begin
        total++; if (wb_tag_o !== 5'd9) begin bad++; $display("FAIL illegal wb_tag got=%0d exp=9", wb_tag_o); end
      end
`else
      total++; if ({wb_valid_o, wb_illegal_o} !== 2'b00) begin bad++; $display("FAIL illegal wb c=%0d got=%b exp=00", c, {wb_valid_o, wb_illegal_o}); end
`endif
      tick();
    end
  endtask

  task automatic test_reset_midop;
    for (int c = 0; c < 6; c++) begin
      rst_i = (c == 3);
      if (c == 0) drive(1'b1, FPU_ADD, 5'd11, 1'b0);
      else        drive(1'b0, FPU_ADD, 5'd0, 1'b0);
      @(negedge clk_i);
      total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid wb_valid c=%0d got=%b exp=0", c, wb_valid_o); end
      if (c == 3) begin
        total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rstmid ready got=%b exp=0", req_ready_o); end
      end
      if (c >= 4) begin
        total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL rstmid idle c=%0d got=%b exp=1", c, idle_o); end
      end
      tick();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, FPU_NOP, 5'd0, 1'b0);
    test_reset();
    test_back_to_back();
    test_collision();
    test_div_occupancy();
    test_flush_div();
    test_flush_wb();
    test_classes();
    test_illegal();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_fpu_issue_ctrl.md
# ibex_fpu_issue_ctrl

In-order, single-issue scheduler between the FP decode stage and the FPU datapath units. It accepts one `fpu_op_e` request per cycle and classifies it by latency. It starts the matching unit (add/convert pipe, multiply/FMA pipe, iterative div/sqrt, single-cycle misc) and reserves the writeback slot so results never collide on the shared register-file write port. It returns each result's tag in the exact cycle the unit produces it, and it can flush all in-flight work.

## Interface
- `ADD_LAT`, default 3: add/sub/convert pipe latency in cycles, legal range 2..30.
- `MUL_LAT`, default 4: mul/FMA pipe latency, legal range 2..30.
- `DIV_LAT`, default 12: div/sqrt iterative latency. Must be greater than `ADD_LAT` and `MUL_LAT`, and at most 31.
- `TAG_W`, default 5: destination tag width.

Ports:
- `clk_i` in 1: clock, rising-edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when both valid and ready are high.
- `req_op_i` in 6: operation, type `ibex_fp_pkg::fpu_op_e`.
- `req_tag_i` in TAG_W: destination tag.
- `flush_i` in 1: kill all in-flight operations.
- `add_start_o`, `mul_start_o`, `div_start_o`, `misc_start_o` out 1 each: one-cycle unit start pulses.
- `unit_op_o` out 6: copy of `req_op_i`, qualified by the start pulses.
- `unit_kill_o` out 1: equals `flush_i`; the units abort their internal state.
- `wb_valid_o` out 1: a result writes back this cycle.
- `wb_tag_o` out TAG_W: tag of that result.
- `wb_illegal_o` out 1: the result is an illegal-op marker (see Configuration).
- `busy_div_o` out 1: div/sqrt unit occupied.
- `idle_o` out 1: no reservations pending and divider free.

## Operation
Each op is classified into a class with a fixed latency L:
- **ADD class, L = ADD_LAT:** FPU_ADD, FPU_SUB, FPU_INT2FLOAT, FPU_INT2FLOAT_U, FPU_FLOAT2INT, FPU_FLOAT2INT_U.
- **MUL class, L = MUL_LAT:** FPU_MUL, FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB.
- **DIV class, L = DIV_LAT:** FPU_DIV, FPU_SQRT.
- **MISC class, L = 1:** FPU_MIN, FPU_MAX, FPU_SGNJ, FPU_SGNJ_N, FPU_SGNJ_X, FPU_MOVE_INT2FLOAT, FPU_MOVE_FLOAT2INT, FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FCLASS.
- **FPU_NOP:** accepted whenever ready is high. It raises no start pulse and produces no writeback.
- **Undefined encodings (above FPU_NOP):** handled as described in Configuration.

Reservation state:
- A DIV_LAT-entry reservation shift register holds a valid bit and a tag per slot.
- Slot k means "writes back k cycles from now".
- All entries shift one slot toward 0 every cycle.
- On issue, slot L is written with the valid bit and `req_tag_i`. Writeback is driven from slot 0, which is registered.

`req_ready_o` is high only when all of the following hold:
- `rst_i` is low.
- `flush_i` is low.
- Slot L for `req_op_i`'s class will be free after this cycle's shift.
- For the DIV class only, `busy_div_o` is low.

Further rules for `req_ready_o`:
- It may depend on `req_op_i`. It must not depend on `req_valid_i`.
- It is held low during reset.

Issue behaviour:
- An issue in cycle t pulses the class's start output in cycle t; these pulses are combinational from the handshake.
- The same issue asserts `wb_valid_o` and `wb_tag_o = req_tag_i` in cycle t+L.

Divider occupancy:
- `busy_div_o` rises in the cycle after a DIV-class issue.
- It falls in that op's writeback cycle. A new DIV may therefore issue in that same writeback cycle.

`idle_o` is high when the reservation register is all-zero and `busy_div_o` is low.

Flush (`flush_i` high in cycle f):
- Issue is blocked in cycle f.
- `wb_valid_o` is forced to 0 in cycle f.
- All reservations and `busy_div_o` are clear from cycle f+1.
- If a request is also valid in cycle f, it is not accepted.

## Timing
- Reset values: `req_ready_o` = 0, all start pulses = 0, `unit_kill_o` = 0, `wb_valid_o` = 0, `wb_tag_o` = 0, `wb_illegal_o` = 0, `busy_div_o` = 0, `idle_o` = 1.
- The first issue is possible in the first cycle after `rst_i` falls.
- Issue-to-writeback latency is exactly L cycles; there is no writeback backpressure.
- Throughput: one issue per cycle for the ADD, MUL and MISC classes when slots are free. DIV class: one issue per DIV_LAT cycles.
- Slot collision: the later request stalls, and `req_valid_i`, `req_op_i` and `req_tag_i` must stay stable until accepted.
- Reset asserted mid-operation: all state is cleared at that edge and no pending writeback is emitted.

## Configuration
Macro `IBEX_FPU_OPCHECK_EN`:
- **Defined:** undefined 6-bit op encodings are accepted as MISC class (L = 1) with no start pulse. Their writeback asserts `wb_valid_o = 1` and `wb_illegal_o = 1` with the request's tag, so the core can raise an illegal-instruction exception.
- **Not defined:** undefined encodings are treated as FPU_NOP, and `wb_illegal_o` is tied to 0.

## Test plan
- **Reset:** hold `rst_i` high for 3 cycles with `req_valid_i = 1` → `req_ready_o` = 0 and all outputs at their reset values; `idle_o` = 1 after release.
- **Back-to-back ADD:** FPU_ADD with tags 1, 2, 3 issued in cycles 0, 1, 2 → `add_start_o` high in cycles 0–2; `wb_valid_o` in cycles 3, 4, 5 with tags 1, 2, 3.
- **Collision:** FPU_MUL tag 7 in cycle 0, FPU_ADD tag 8 valid from cycle 1 → ready low in cycle 1, ADD issues in cycle 2; writebacks are tag 7 in cycle 4 and tag 8 in cycle 5.
- **Divider occupancy:** FPU_DIV tag 4 in cycle 0, FPU_SQRT tag 5 valid from cycle 1 → SQRT issues in cycle 12; writebacks are tag 4 in cycle 12 and tag 5 in cycle 24; `busy_div_o` stays high from cycle 1 through cycle 23 (the writeback cycle 12 does not clear it because the SQRT issues there).
- **Flush mid-DIV:** FPU_DIV in cycle 0, `flush_i` in cycle 5 → `unit_kill_o` high in cycle 5; `busy_div_o` = 0 and `idle_o` = 1 in cycle 6; no writeback in cycle 12.
- **Illegal op:** encoding 6'd40 with tag 9 in cycle 0 → with `IBEX_FPU_OPCHECK_EN`: `wb_valid_o`, `wb_illegal_o` and tag 9 in cycle 1; without it: no writeback.
